// File: rtl/i2c_touch_pkg.sv
// Shared types and the fixed register-write init table for the touch sensor.
package i2c_touch_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_INIT_ISSUE = 3'd1,
        S_INIT_WAIT  = 3'd2,
        S_POLL_GAP   = 3'd3,
        S_POLL_ISSUE = 3'd4,
        S_POLL_WAIT  = 3'd5,
        S_FAULT      = 3'd6
    } state_t;

    typedef struct packed {
        logic [7:0] rg;
        logic [7:0] val;
    } init_entry_t;

    localparam int INIT_LEN = 7;
    localparam int IDX_W    = $clog2(INIT_LEN);

    // Soft reset, stop, electrode 0/1 touch/release thresholds, then run.
    localparam init_entry_t INIT_TABLE [INIT_LEN] = '{
        '{8'h80, 8'h63},
        '{8'h5E, 8'h00},
        '{8'h41, 8'h0C},
        '{8'h42, 8'h06},
        '{8'h43, 8'h0C},
        '{8'h44, 8'h06},
        '{8'h5E, 8'h8C}
    };

endpackage

// File: rtl/i2c_touch_sequencer_if.sv
// Command/response bundle between the touch sequencer and the I2C controller.
interface i2c_touch_sequencer_if;

    logic       i2c_start_out;
    logic [6:0] i2c_addr_out;
    logic       i2c_rw_out;
    logic [7:0] i2c_cmd_out;
    logic [7:0] i2c_data_out;
    logic [7:0] i2c_data_in;
    logic       i2c_valid_in;

    modport master (
        output i2c_start_out, i2c_addr_out, i2c_rw_out, i2c_cmd_out, i2c_data_out,
        input  i2c_data_in, i2c_valid_in
    );

    modport slave (
        input  i2c_start_out, i2c_addr_out, i2c_rw_out, i2c_cmd_out, i2c_data_out,
        output i2c_data_in, i2c_valid_in
    );

endinterface

// File: rtl/i2c_touch_sequencer_timer.sv
// Loadable down-counter: load_in presets LIMIT-1, en_in counts toward zero,
// done_out is high while the count sits at zero.
module i2c_txn_timer #(
    parameter int unsigned LIMIT = 2
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic load_in,
    input  logic en_in,
    output logic done_out
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LOAD_VAL = W'(LIMIT - 1);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count_q <= '0;
        end else if (load_in) begin
            count_q <= LOAD_VAL;
        end else if (en_in && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done_out = (count_q == '0);

endmodule

// File: rtl/i2c_touch_sequencer.sv
// Runs the sensor init table after enable, then polls the touch-status register
// with timeout/retry, publishing the touch bitmap and latching a fault.
module i2c_touch_sequencer
    import i2c_touch_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR       = 7'h5A,
    parameter logic [7:0]  STATUS_REG     = 8'h00,
    parameter int unsigned POLL_CYCLES    = 1_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter int unsigned MAX_FAIL       = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  enable_in,
    i2c_touch_sequencer_if.master bus,
    output logic                  init_done_out,
    output logic [7:0]            touch_out,
    output logic                  touch_valid_out,
    output logic                  touch_changed_out,
    output logic                  error_out
);

    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(INIT_LEN - 1);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAIL);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [FAIL_W-1:0]   fail_q, fail_d, fail_inc;
    logic                start_q, start_d;
    logic                rw_q, rw_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [7:0]          data_q, data_d;
    logic [7:0]          touch_q, touch_d;
    logic                tvalid_q, tvalid_d;
    logic                tchg_q, tchg_d;
    logic                init_done_q, init_done_d;
    logic                err_q, err_d;

    logic                in_wait, gap_load, gap_done, to_done, timeout;
    init_entry_t         entry;

    assign in_wait  = (state_q == S_INIT_WAIT) || (state_q == S_POLL_WAIT);
    assign gap_load = (state_d == S_POLL_GAP) && (state_q != S_POLL_GAP);
    // The timeout counter is preset while the start pulse is out, so the
    // stale count cannot fire during that first WAIT cycle.
    assign timeout  = in_wait && !start_q && to_done;
    assign fail_inc = fail_q + 1'b1;
    assign entry    = INIT_TABLE[idx_q];

    i2c_txn_timer #(.LIMIT(POLL_CYCLES)) u_gap_timer (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .load_in  (gap_load),
        .en_in    (state_q == S_POLL_GAP),
        .done_out (gap_done)
    );

    i2c_txn_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timeout_timer (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .load_in  (start_q),
        .en_in    (in_wait),
        .done_out (to_done)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        fail_d      = fail_q;
        start_d     = 1'b0;
        rw_d        = rw_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        touch_d     = touch_q;
        tvalid_d    = 1'b0;
        tchg_d      = 1'b0;
        init_done_d = init_done_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (enable_in) state_d = S_INIT_ISSUE;
            end
            S_INIT_ISSUE: begin
                start_d = 1'b1;
                rw_d    = 1'b0;
                cmd_d   = entry.rg;
                data_d  = entry.val;
                state_d = enable_in ? S_INIT_WAIT : S_IDLE;
            end
            S_INIT_WAIT: begin
                if (bus.i2c_valid_in) begin
                    fail_d = '0;
                    if (!enable_in) begin
                        state_d = S_IDLE;
                    end else if (idx_q == IDX_LAST) begin
                        init_done_d = 1'b1;
                        state_d     = S_POLL_GAP;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_INIT_ISSUE;
                    end
                end else if (timeout) begin
                    fail_d = fail_inc;
                    if (!enable_in) begin
                        state_d = S_IDLE;
                    end else if (fail_inc == FAIL_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_INIT_ISSUE;
                    end
                end
            end
            S_POLL_GAP: begin
                if (!enable_in)    state_d = S_IDLE;
                else if (gap_done) state_d = S_POLL_ISSUE;
            end
            S_POLL_ISSUE: begin
                start_d = 1'b1;
                rw_d    = 1'b1;
                cmd_d   = STATUS_REG;
                data_d  = 8'h00;
                state_d = enable_in ? S_POLL_WAIT : S_IDLE;
            end
            S_POLL_WAIT: begin
                // A finishing read is published even if enable has dropped.
                if (bus.i2c_valid_in) begin
                    fail_d   = '0;
                    touch_d  = bus.i2c_data_in;
                    tvalid_d = 1'b1;
                    tchg_d   = (bus.i2c_data_in != touch_q);
                    state_d  = enable_in ? S_POLL_GAP : S_IDLE;
                end else if (timeout) begin
                    fail_d = fail_inc;
                    if (!enable_in) begin
                        state_d = S_IDLE;
                    end else if (fail_inc == FAIL_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_POLL_ISSUE;
                    end
                end
            end
            S_FAULT: begin
                if (!enable_in) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_IDLE) begin
            idx_d       = '0;
            fail_d      = '0;
            init_done_d = 1'b0;
            err_d       = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            fail_q      <= '0;
            start_q     <= 1'b0;
            rw_q        <= 1'b0;
            cmd_q       <= '0;
            data_q      <= '0;
            touch_q     <= '0;
            tvalid_q    <= 1'b0;
            tchg_q      <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            fail_q      <= fail_d;
            start_q     <= start_d;
            rw_q        <= rw_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            touch_q     <= touch_d;
            tvalid_q    <= tvalid_d;
            tchg_q      <= tchg_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
        end
    end

    assign bus.i2c_start_out = start_q;
    assign bus.i2c_addr_out  = DEV_ADDR;
    assign bus.i2c_rw_out    = rw_q;
    assign bus.i2c_cmd_out   = cmd_q;
    assign bus.i2c_data_out  = data_q;

    assign init_done_out     = init_done_q;
    assign touch_out         = touch_q;
    assign touch_valid_out   = tvalid_q;
    assign touch_changed_out = tchg_q;
    assign error_out         = err_q;

endmodule

// File: tb/tb_i2c_touch_sequencer.sv
// Directed bench: behavioural controller model plus per-scenario checking tasks.
module tb_i2c_touch_sequencer;

    localparam int P     = 20;
    localparam int T     = 40;
    localparam int MF    = 3;
    localparam int NINIT = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       init_done, tv, tc, err;
    logic [7:0] touch;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int         st_cnt = 0;
    logic       st_rw  [64];
    logic [7:0] st_cmd [64];
    logic [7:0] st_dat [64];
    int         st_cyc [64];
    int         drop_from = 1000;
    int         drop_to = 1000;
    int         lat_wr = 3;
    int         lat_rd = 3;
    logic [7:0] rd_vals [4];
    int         rd_idx = 0;

    int         tv_cnt = 0;
    logic       tv_chg [16];
    logic [7:0] tv_dat [16];
    int         tv_cyc [16];
    int         done_cyc = -1;

    logic [7:0] exp_reg [NINIT] = '{8'h80, 8'h5E, 8'h41, 8'h42, 8'h43, 8'h44, 8'h5E};
    logic [7:0] exp_val [NINIT] = '{8'h63, 8'h00, 8'h0C, 8'h06, 8'h0C, 8'h06, 8'h8C};

    i2c_touch_sequencer_if bus ();

    i2c_touch_sequencer #(
        .DEV_ADDR       (7'h5A),
        .STATUS_REG     (8'h00),
        .POLL_CYCLES    (P),
        .TIMEOUT_CYCLES (T),
        .MAX_FAIL       (MF)
    ) dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .enable_in         (enable),
        .bus               (bus),
        .init_done_out     (init_done),
        .touch_out         (touch),
        .touch_valid_out   (tv),
        .touch_changed_out (tc),
        .error_out         (err)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    // Controller model: logs every start, answers after a latency unless dropped.
    initial begin : ctrl_model
        int n;
        int l;
        logic rw;
        bus.i2c_valid_in = 1'b0;
        bus.i2c_data_in  = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (rst_n && bus.i2c_start_out) begin
                n  = st_cnt;
                rw = bus.i2c_rw_out;
                if (n < 64) begin
                    st_rw[n]  = rw;
                    st_cmd[n] = bus.i2c_cmd_out;
                    st_dat[n] = bus.i2c_data_out;
                    st_cyc[n] = cyc;
                end
                st_cnt++;
                if (n < drop_from || n >= drop_to) begin
                    l = rw ? lat_rd : lat_wr;
                    repeat (l) begin @(posedge clk); #1; end
                    if (rst_n) begin
                        bus.i2c_valid_in = 1'b1;
                        bus.i2c_data_in  = (rw && rd_idx < 4) ? rd_vals[rd_idx] : 8'h00;
                        if (rw) rd_idx++;
                        @(posedge clk); #1;
                        bus.i2c_valid_in = 1'b0;
                        bus.i2c_data_in  = 8'h00;
                    end
                end
            end
        end
    end

    initial begin : touch_mon
        forever begin
            @(posedge clk); #1;
            if (tv) begin
                if (tv_cnt < 16) begin
                    tv_chg[tv_cnt] = tc;
                    tv_dat[tv_cnt] = touch;
                    tv_cyc[tv_cnt] = cyc;
                end
                tv_cnt++;
            end
            if (init_done && done_cyc < 0) done_cyc = cyc;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (12) @(negedge clk);
        st_cnt = 0; drop_from = 1000; drop_to = 1000;
        lat_wr = 3; lat_rd = 3; rd_idx = 0;
        tv_cnt = 0; done_cyc = -1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.i2c_start_out, bus.i2c_addr_out, bus.i2c_rw_out, bus.i2c_cmd_out, bus.i2c_data_out}
            !== {1'b0, 7'h5A, 1'b0, 8'h00, 8'h00}) begin
            failures++;
            $display("FAIL reset_bus got=%h want=%h", {bus.i2c_start_out, bus.i2c_addr_out,
                     bus.i2c_rw_out, bus.i2c_cmd_out, bus.i2c_data_out}, {1'b0, 7'h5A, 1'b0, 16'h0});
        end
        checks++;
        if ({init_done, touch, tv, tc, err} !== 12'h000) begin
            failures++;
            $display("FAIL reset_status got=%h want=000", {init_done, touch, tv, tc, err});
        end
    endtask

    task automatic test_init();
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 2000 && !init_done; i++) @(negedge clk);
        checks++;
        if (init_done !== 1'b1) begin
            failures++; $display("FAIL init_done got=%b want=1", init_done);
        end
        checks++;
        if (st_cnt !== NINIT) begin
            failures++; $display("FAIL init_starts got=%0d want=%0d", st_cnt, NINIT);
        end
        for (int i = 0; i < NINIT; i++) begin
            checks++;
            if ({st_rw[i], st_cmd[i], st_dat[i]} !== {1'b0, exp_reg[i], exp_val[i]}) begin
                failures++;
                $display("FAIL init_entry%0d got=%h want=%h", i, {st_rw[i], st_cmd[i], st_dat[i]},
                         {1'b0, exp_reg[i], exp_val[i]});
            end
        end
        checks++;
        if (err !== 1'b0) begin
            failures++; $display("FAIL init_err got=%b want=0", err);
        end
    endtask

    task automatic test_poll();
        rd_vals[0] = 8'h05; rd_vals[1] = 8'h05; rd_vals[2] = 8'h01; rd_vals[3] = 8'h01;
        for (int i = 0; i < 400 && tv_cnt < 3; i++) @(negedge clk);
        checks++;
        if (tv_cnt !== 3) begin
            failures++; $display("FAIL poll_count got=%0d want=3", tv_cnt);
        end
        checks++;
        if ({tv_chg[0], tv_chg[1], tv_chg[2]} !== 3'b101) begin
            failures++; $display("FAIL poll_changed got=%b want=101", {tv_chg[0], tv_chg[1], tv_chg[2]});
        end
        checks++;
        if ({tv_dat[0], tv_dat[1], tv_dat[2]} !== 24'h050501) begin
            failures++; $display("FAIL poll_data got=%h want=050501", {tv_dat[0], tv_dat[1], tv_dat[2]});
        end
        checks++;
        if (touch !== 8'h01) begin
            failures++; $display("FAIL poll_touch got=%h want=01", touch);
        end
        checks++;
        if ({st_rw[NINIT], st_cmd[NINIT], st_dat[NINIT]} !== {1'b1, 8'h00, 8'h00}) begin
            failures++; $display("FAIL poll_cmd got=%h want=10000", {st_rw[NINIT], st_cmd[NINIT], st_dat[NINIT]});
        end
        checks++;
        if (st_cyc[NINIT] !== done_cyc + P + 1) begin
            failures++; $display("FAIL poll_first_gap got=%0d want=%0d", st_cyc[NINIT], done_cyc + P + 1);
        end
        checks++;
        if (tv_cyc[0] !== st_cyc[NINIT] + lat_rd + 1) begin
            failures++; $display("FAIL poll_latency got=%0d want=%0d", tv_cyc[0], st_cyc[NINIT] + lat_rd + 1);
        end
        checks++;
        if (st_cyc[NINIT+1] !== tv_cyc[0] + P + 1) begin
            failures++; $display("FAIL poll_next_gap got=%0d want=%0d", st_cyc[NINIT+1], tv_cyc[0] + P + 1);
        end
    endtask

    task automatic test_timeout_retry();
        do_reset();
        drop_from = 2; drop_to = 3;
        enable = 1'b1;
        for (int i = 0; i < 3000 && !init_done; i++) @(negedge clk);
        checks++;
        if (init_done !== 1'b1 || err !== 1'b0) begin
            failures++; $display("FAIL retry_done got=%b%b want=10", init_done, err);
        end
        checks++;
        if (st_cnt !== NINIT + 1) begin
            failures++; $display("FAIL retry_starts got=%0d want=%0d", st_cnt, NINIT + 1);
        end
        checks++;
        if ({st_cmd[2], st_dat[2], st_cmd[3], st_dat[3]} !== {exp_reg[2], exp_val[2], exp_reg[2], exp_val[2]}) begin
            failures++;
            $display("FAIL retry_entry got=%h want=%h", {st_cmd[2], st_dat[2], st_cmd[3], st_dat[3]},
                     {exp_reg[2], exp_val[2], exp_reg[2], exp_val[2]});
        end
        checks++;
        if (st_cyc[3] - st_cyc[2] !== T + 2) begin
            failures++; $display("FAIL retry_timing got=%0d want=%0d", st_cyc[3] - st_cyc[2], T + 2);
        end
        checks++;
        if ({st_cmd[NINIT], st_dat[NINIT]} !== {exp_reg[NINIT-1], exp_val[NINIT-1]}) begin
            failures++; $display("FAIL retry_last got=%h want=5e8c", {st_cmd[NINIT], st_dat[NINIT]});
        end
    endtask

    task automatic test_fault();
        do_reset();
        drop_from = 1; drop_to = 1000;
        enable = 1'b1;
        for (int i = 0; i < 3000 && !err; i++) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            failures++; $display("FAIL fault_err got=%b want=1", err);
        end
        checks++;
        if (st_cnt !== 1 + MF) begin
            failures++; $display("FAIL fault_starts got=%0d want=%0d", st_cnt, 1 + MF);
        end
        for (int i = 1; i <= MF; i++) begin
            checks++;
            if ({st_cmd[i], st_dat[i]} !== 16'h5E00) begin
                failures++; $display("FAIL fault_entry%0d got=%h want=5e00", i, {st_cmd[i], st_dat[i]});
            end
        end
        repeat (3 * T) @(negedge clk);
        checks++;
        if (st_cnt !== 1 + MF || err !== 1'b1) begin
            failures++; $display("FAIL fault_hold got=%0d/%b want=%0d/1", st_cnt, err, 1 + MF);
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({err, init_done} !== 2'b00) begin
            failures++; $display("FAIL fault_clear got=%b want=00", {err, init_done});
        end
        st_cnt = 0; drop_from = 1000; drop_to = 1000;
        enable = 1'b1;
        for (int i = 0; i < 50 && st_cnt < 1; i++) @(negedge clk);
        checks++;
        if ({st_cmd[0], st_dat[0]} !== 16'h8063) begin
            failures++; $display("FAIL fault_restart got=%h want=8063", {st_cmd[0], st_dat[0]});
        end
    endtask

    task automatic test_disable_poll();
        do_reset();
        lat_rd = 10;
        rd_vals[0] = 8'hAA;
        enable = 1'b1;
        for (int i = 0; i < 2000 && !init_done; i++) @(negedge clk);
        for (int i = 0; i < 100 && st_cnt < NINIT + 1; i++) @(negedge clk);
        enable = 1'b0;
        checks++;
        if (st_rw[NINIT] !== 1'b1) begin
            failures++; $display("FAIL dis_read_started got=%b want=1", st_rw[NINIT]);
        end
        for (int i = 0; i < 50 && tv_cnt < 1; i++) @(negedge clk);
        checks++;
        if (touch !== 8'hAA || tv_chg[0] !== 1'b1) begin
            failures++; $display("FAIL dis_publish got=%h/%b want=aa/1", touch, tv_chg[0]);
        end
        repeat (3 * P) @(negedge clk);
        checks++;
        if (st_cnt !== NINIT + 1) begin
            failures++; $display("FAIL dis_no_starts got=%0d want=%0d", st_cnt, NINIT + 1);
        end
        checks++;
        if ({init_done, err} !== 2'b00) begin
            failures++; $display("FAIL dis_idle got=%b want=00", {init_done, err});
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drop_from = 0; drop_to = 1000;
        enable = 1'b1;
        for (int i = 0; i < 20 && st_cnt < 1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.i2c_cmd_out, bus.i2c_data_out} !== 16'h8063) begin
            failures++; $display("FAIL areset_pre got=%h want=8063", {bus.i2c_cmd_out, bus.i2c_data_out});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.i2c_start_out, bus.i2c_addr_out, bus.i2c_rw_out, bus.i2c_cmd_out, bus.i2c_data_out,
             init_done, touch, tv, tc, err} !== {1'b0, 7'h5A, 1'b0, 16'h0, 12'h000}) begin
            failures++;
            $display("FAIL areset_now got=%h want=%h", {bus.i2c_start_out, bus.i2c_addr_out, bus.i2c_rw_out,
                     bus.i2c_cmd_out, bus.i2c_data_out, init_done, touch, tv, tc, err},
                     {1'b0, 7'h5A, 1'b0, 16'h0, 12'h000});
        end
        @(negedge clk);
        enable = 1'b0;
        rst_n  = 1'b1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin : main
        test_reset();
        test_init();
        test_poll();
        test_timeout_retry();
        test_fault();
        test_disable_poll();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
